tdsp_clk_gate_ctrl: RTL and testbench

//   Generates the tdsp_clk_enable qualifier that the test clock mux ANDs with clk
//   to form the gated DSP clock.

---
 rtl/tdsp_clk_gate_ctrl.sv | 106 ++++++++++
 tb/tb_tdsp_clk_gate_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/tdsp_clk_gate_ctrl.sv
// DSP clock-gate controller: wakes the gated DSP clock on request, acknowledges after a settle
// period, and gates it off after a run of idle cycles; the enable launches on negedge so the AND is glitch-free.
module tdsp_clk_gate_ctrl #(
    parameter int WAKE_CYCLES = 4,
    parameter int IDLE_CYCLES = 16,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       test_mode,
    input  logic       tdsp_req,
    input  logic       tdsp_busy,
    input  logic       force_on,
    output logic       tdsp_clk_enable,
    output logic       tdsp_ack,
    output logic [1:0] gate_state
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_WAKE  = 2'd1,
        ST_ON    = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_ack;
    logic             r_en;
    logic             w_ack_nxt;
    logic             w_en_nxt;
    logic             w_wake;
    logic             w_quiet;

    assign w_wake  = tdsp_req | force_on;
    assign w_quiet = ~tdsp_req & ~tdsp_busy & ~force_on;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_OFF;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= w_ack_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (test_mode) begin
            w_state_nxt = ST_OFF;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    if (w_wake) begin
                        w_state_nxt = ST_WAKE;
                        w_cnt_nxt   = WAKE_LOAD;
                    end
                end
                ST_WAKE: begin
                    // requests are ignored until the clock has settled
                    if (r_cnt == '0) w_state_nxt = ST_ON;
                    else             w_cnt_nxt   = r_cnt - CNT_ONE;
                end
                ST_ON: begin
                    if (w_quiet) begin
                        w_state_nxt = ST_DRAIN;
                        w_cnt_nxt   = IDLE_LOAD;
                    end
                end
                ST_DRAIN: begin
                    if (!w_quiet)          w_state_nxt = ST_ON;
                    else if (r_cnt == '0)  w_state_nxt = ST_OFF;
                    else                   w_cnt_nxt   = r_cnt - CNT_ONE;
                end
                default: w_state_nxt = ST_OFF;
            endcase
        end
    end

    always_comb begin
        w_ack_nxt = (w_state_nxt == ST_ON);
        w_en_nxt  = (r_state != ST_OFF);
    end

    // enable only changes while clk is low, so the downstream AND never glitches
    always_ff @(negedge clk or posedge rst) begin
        if (rst) r_en <= 1'b0;
        else     r_en <= w_en_nxt;
    end

    assign tdsp_clk_enable = r_en;
    assign tdsp_ack        = r_ack;
    assign gate_state      = r_state;

endmodule

// File: tb/tb_tdsp_clk_gate_ctrl.sv
// Scoreboard bench for tdsp_clk_gate_ctrl: directed scenarios then random stimulus, checked
// against a cycle-counting reference model.
module tb_tdsp_clk_gate_ctrl;

    localparam int WAKE_CYCLES = 4;
    localparam int IDLE_CYCLES = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       test_mode = 1'b0;
    logic       tdsp_req = 1'b0;
    logic       tdsp_busy = 1'b0;
    logic       force_on = 1'b0;
    logic       tdsp_clk_enable;
    logic       tdsp_ack;
    logic [1:0] gate_state;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0] st;
        logic       ack;
    } exp_t;

    exp_t exp_q[$];

    // reference model: phase plus elapsed-cycle counts
    int m_phase = 0;       // 0 off, 1 waking, 2 on, 3 draining
    int m_wake_elapsed = 0;
    int m_quiet_run = 0;

    tdsp_clk_gate_ctrl #(
        .WAKE_CYCLES(WAKE_CYCLES),
        .IDLE_CYCLES(IDLE_CYCLES),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .test_mode(test_mode),
        .tdsp_req(tdsp_req),
        .tdsp_busy(tdsp_busy),
        .force_on(force_on),
        .tdsp_clk_enable(tdsp_clk_enable),
        .tdsp_ack(tdsp_ack),
        .gate_state(gate_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_wake_elapsed = 0;
        m_quiet_run = 0;
    endtask

    task automatic model_step();
        bit wake;
        bit quiet;
        exp_t e;
        wake  = tdsp_req || force_on;
        quiet = !tdsp_req && !tdsp_busy && !force_on;
        if (rst || test_mode) begin
            model_reset();
        end else begin
            case (m_phase)
                0: if (wake) begin
                    m_phase = 1;
                    m_wake_elapsed = 0;
                end
                1: begin
                    m_wake_elapsed++;
                    if (m_wake_elapsed >= WAKE_CYCLES) m_phase = 2;
                end
                2: if (quiet) begin
                    m_phase = 3;
                    m_quiet_run = 1;
                end
                default: begin
                    if (!quiet) begin
                        m_phase = 2;
                    end else begin
                        m_quiet_run++;
                        if (m_quiet_run > IDLE_CYCLES) m_phase = 0;
                    end
                end
            endcase
        end
        e.st  = 2'(m_phase);
        e.ack = (m_phase == 2);
        exp_q.push_back(e);
    endtask

    // one clock cycle: drive inputs while clk is low, optionally pulse async reset first
    task automatic cyc(input bit r, input bit req, input bit busy, input bit frc, input bit tm, input bit pulse);
        @(negedge clk);
        #2;
        if (pulse) begin
            rst = 1'b1;
            #1;
            chk("async_rst_enable", {1'b0, tdsp_clk_enable}, 2'd0);
            chk("async_rst_ack", {1'b0, tdsp_ack}, 2'd0);
            chk("async_rst_state", gate_state, 2'd0);
            model_reset();
        end
        rst       = r;
        tdsp_req  = req;
        tdsp_busy = busy;
        force_on  = frc;
        test_mode = tm;
        @(posedge clk);
        model_step();
    endtask

    // monitor: state/ack after each posedge, enable after the following negedge
    initial begin : monitor
        exp_t e;
        bit   en_pend;
        logic en_exp;
        en_pend = 1'b0;
        en_exp  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("gate_state", gate_state, e.st);
                chk("ack", {1'b0, tdsp_ack}, {1'b0, e.ack});
                en_exp  = (e.st != 2'd0);
                en_pend = 1'b1;
            end
            @(negedge clk);
            #1;
            if (en_pend) chk("enable", {1'b0, tdsp_clk_enable}, {1'b0, en_exp});
            en_pend = 1'b0;
        end
    end

    // enable must never move while clk is high
    always @(tdsp_clk_enable) begin
        if ($time > 2) begin
            checks++;
            if (clk === 1'b1) begin
                failures++;
                $display("FAIL enable_glitch at %0t: enable changed to %0b while clk=1 (required clk=0)", $time, tdsp_clk_enable);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit r_req, r_busy, r_frc, r_tm;
        #1;
        rst = 1'b1;
        #1;
        chk("reset_state", gate_state, 2'd0);
        chk("reset_ack", {1'b0, tdsp_ack}, 2'd0);
        chk("reset_enable", {1'b0, tdsp_clk_enable}, 2'd0);
        repeat (2) cyc(1, 0, 0, 0, 0, 0);

        // wake and settle
        repeat (8) cyc(0, 1, 0, 0, 0, 0);
        // idle gate-off
        repeat (20) cyc(0, 0, 0, 0, 0, 0);
        // drain abort with busy, then full drain
        repeat (8) cyc(0, 1, 0, 0, 0, 0);
        repeat (11) cyc(0, 0, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 1, 0, 0, 0);
        repeat (20) cyc(0, 0, 0, 0, 0, 0);
        // test_mode mid-ON, then fresh wake
        repeat (8) cyc(0, 1, 0, 0, 0, 0);
        repeat (2) cyc(0, 1, 0, 0, 1, 0);
        repeat (8) cyc(0, 1, 0, 0, 0, 0);
        repeat (20) cyc(0, 0, 0, 0, 0, 0);
        // async reset mid-wake, then full wake
        repeat (2) cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 1);
        repeat (8) cyc(0, 1, 0, 0, 0, 0);
        // busy alone does not wake from OFF
        repeat (20) cyc(0, 0, 0, 0, 0, 0);
        repeat (5) cyc(0, 0, 1, 0, 0, 0);
        // force_on holds the clock, then clearing it drains
        repeat (30) cyc(0, 0, 0, 1, 0, 0);
        repeat (20) cyc(0, 0, 0, 0, 0, 0);

        // random runs of held inputs
        r_req = 0; r_busy = 0; r_frc = 0; r_tm = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) r_req  = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) r_busy = $urandom_range(0, 1);
            if ($urandom_range(0, 15) == 0) r_frc = ($urandom_range(0, 3) == 0);
            r_tm = ($urandom_range(0, 99) == 0);
            cyc(0, r_req, r_busy, r_frc, r_tm, $urandom_range(0, 499) == 0);
        end
        repeat (20) cyc(0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
